ex_issue_sched: RTL and testbench
=================================

Name: ex_issue_sched

Overview:
- Issue scheduler between the decode stage and the single-cycle Executer datapath, plus one iterative multi-cycle unit (DIV/MUL).
- Accepts one decoded operation per cycle over a valid/ready handshake and classifies it as single-cycle or multi-cycle.
- Drives the Executer select and destination fields, tracks the one outstanding multi-cycle op, and blocks issue on RAW/WAW hazards and writeback-port collisions.
- Produces a single writeback-valid stream toward the register file.

Parameters:
- DIV_LAT, 35, cycles from DIV issue to its writeback (legal range 2..63).
- MUL_LAT, 2, cycles from MUL issue to its writeback (legal range 2..63).
- NOP_SEL, 10'h200, select value driven to the Executer when idle; matches no Executer operation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid_i  in  1  decode presents an op.
- id_ready_o  out  1  scheduler accepts the op this cycle.
- id_sel_i  in  10  circuit select of the op.
- id_src1_i  in  5  first source register number.
- id_src2_i  in  5  second source register number.
- id_dst_i  in  5  destination register number.
- id_dst2_i  in  5  second destination register number (DIV remainder, MUL high word).
- flush_i  in  1  pipeline flush request.
- ex_fire_o  out  1  Executer enable this cycle.
- ex_sel_o  out  10  circuit select to the Executer.
- ex_dst_o  out  5  destination field to the Executer.
- ex_dst2_o  out  5  second destination field to the Executer.
- wb_valid_o  out  1  result is valid for writeback this cycle.
- wb_dst_o  out  5  writeback destination.
- wb_dst2_o  out  5  writeback second destination (0 = none).
- wb_multi_o  out  1  writeback comes from the multi-cycle unit.
- busy_o  out  1  a multi-cycle op is outstanding.

Behaviour:
- Reset (rst_n low, asynchronous): state goes to IDLE; counter = 0; busy_o, wb_valid_o and wb_multi_o = 0; wb_dst_o and wb_dst2_o = 0; ex_sel_o = NOP_SEL; ex_fire_o = 0.
- Classification:
  - id_sel_i == 10'h008 is DIV (latency DIV_LAT).
  - id_sel_i == 10'h080 is MUL (latency MUL_LAT).
  - Every other value is single-cycle.
- Issue:
  - fire = id_valid_i & id_ready_o, evaluated combinationally.
  - When fire: ex_fire_o = 1, and ex_sel_o, ex_dst_o, ex_dst2_o pass through from id_sel_i, id_dst_i, id_dst2_i.
  - When not firing: ex_sel_o = NOP_SEL, ex_dst_o = 0, ex_dst2_o = 0.
- State machine, two states:
  - IDLE: no multi-cycle op outstanding.
  - BUSY: one multi-cycle op outstanding; latched dst/dst2; counter running.
- id_ready_o = 0 whenever any of these holds:
  - flush_i = 1.
  - BUSY and the incoming op is multi-cycle (only one may be outstanding).
  - BUSY and id_src1_i, id_src2_i or id_dst_i equals a latched multi dst/dst2 that is nonzero. r0 never creates a hazard.
  - BUSY and counter == 1 and the incoming op is single-cycle (writeback-port collision; the multi-cycle op wins).
- Otherwise id_ready_o = 1.
- Single-cycle op fired at cycle T:
  - wb_valid_o = 1 in T+1 with wb_dst_o = dst, wb_dst2_o = 0, wb_multi_o = 0.
- Multi-cycle op fired at cycle T:
  - IDLE -> BUSY; latch dst/dst2; counter = LAT-1.
  - Counter decrements each cycle.
  - In cycle T+LAT: wb_valid_o = 1, wb_multi_o = 1, wb_dst_o/wb_dst2_o = latched values.
  - The FSM returns to IDLE on the edge ending T+LAT-1, so a new op may fire in T+LAT.
- busy_o = 1 exactly while in BUSY.
- Flush (flush_i = 1 in cycle F):
  - Suppresses every writeback for ops fired at or before F; wb_valid_o = 0 in F+1.
  - BUSY -> IDLE; counter cleared.
  - If a multi-cycle writeback is already due in F itself, it still completes.
- Reset mid-operation: any outstanding op is discarded and no writeback is emitted after rst_n deasserts.
- Counter width: 6 bits.

Optional Feature:
- Macro EXSCHED_PERF_EN.
- When defined, three 32-bit output ports are added, all reset to 0, each wrapping at 2^32:
  - perf_issue_o: count of fires.
  - perf_stall_o: count of cycles with id_valid_i & !id_ready_o.
  - perf_multi_o: count of multi-cycle completions.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then single ADD: id_sel=10'h020, dst=5 at T -> ex_fire_o=1 and ex_sel_o=10'h020 in T; wb_valid_o=1, wb_dst_o=5, wb_multi_o=0 in T+1.
- DIV dst=3, dst2=4 at T with DIV_LAT=35 -> busy_o=1 for T+1..T+34; wb_valid_o=1, wb_multi_o=1, wb_dst_o=3, wb_dst2_o=4 in T+35; a second DIV presented at T+1 is held with id_ready_o=0 until T+35.
- During DIV (dst=3), an op with src1=3 -> stalled until the DIV writeback cycle; an independent op src=7/8, dst=9 -> issues at once and writes back in the next cycle.
- MUL at T (MUL_LAT=2), independent single op presented at T+1 -> id_ready_o=0 at T+1 (collision); the op issues at T+2 and writes back at T+3; the MUL writes back at T+2.
- DIV in flight, flush_i pulsed at T+10 -> busy_o=0 from T+11; no wb_valid_o through T+40; id_ready_o=0 only in T+10.
- rst_n asserted low mid-DIV -> all outputs return to reset values immediately (asynchronously); no writeback after release. With EXSCHED_PERF_EN: 3 issues and 2 stall cycles give perf_issue_o=3, perf_stall_o=2.

Source files
------------

// File: rtl/ex_issue_sched.sv
// ex_issue_sched
// Issue scheduler sitting between decode and the single-cycle Executer,
// with bookkeeping for one iterative multi-cycle unit (DIV / MUL).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   id_valid_i/id_ready_o, id_sel_i, id_src1_i, id_src2_i, id_dst_i, id_dst2_i
//                     decoded op handshake and fields
//   flush_i           pipeline flush request
//   ex_fire_o, ex_sel_o, ex_dst_o, ex_dst2_o
//                     Executer enable, circuit select and destinations
//   wb_valid_o, wb_dst_o, wb_dst2_o, wb_multi_o
//                     single writeback stream toward the register file
//   busy_o            a multi-cycle op is outstanding
//
// Optional feature macro: EXSCHED_PERF_EN adds perf_issue_o, perf_stall_o
// and perf_multi_o (32-bit wrapping event counters).
`timescale 1ns/1ps

module ex_issue_sched #(
    parameter int unsigned DIV_LAT = 35,
    parameter int unsigned MUL_LAT = 2,
    parameter logic [9:0]  NOP_SEL = 10'h200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid_i,
    output logic        id_ready_o,
    input  logic [9:0]  id_sel_i,
    input  logic [4:0]  id_src1_i,
    input  logic [4:0]  id_src2_i,
    input  logic [4:0]  id_dst_i,
    input  logic [4:0]  id_dst2_i,
    input  logic        flush_i,
    output logic        ex_fire_o,
    output logic [9:0]  ex_sel_o,
    output logic [4:0]  ex_dst_o,
    output logic [4:0]  ex_dst2_o,
    output logic        wb_valid_o,
    output logic [4:0]  wb_dst_o,
    output logic [4:0]  wb_dst2_o,
    output logic        wb_multi_o,
    output logic        busy_o
`ifdef EXSCHED_PERF_EN
    ,
    output logic [31:0] perf_issue_o,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_multi_o
`endif
);

    localparam logic [9:0] SEL_DIV = 10'h008;
    localparam logic [9:0] SEL_MUL = 10'h080;
    localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);
    localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_next;
    logic [5:0] count, count_next;
    logic [4:0] multi_dst, multi_dst2;
    logic       is_div, is_mul, is_multi, busy;
    logic       hazard, collision, ready, fire, multi_done;

    // A register hazard only exists against a nonzero latched destination.
    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] m);
        return (m != 5'd0) && (r == m);
    endfunction

    assign is_div   = (id_sel_i == SEL_DIV);
    assign is_mul   = (id_sel_i == SEL_MUL);
    assign is_multi = is_div | is_mul;
    assign busy     = (state == BUSY);

    assign hazard = busy & (reg_match(id_src1_i, multi_dst) | reg_match(id_src1_i, multi_dst2) |
                            reg_match(id_src2_i, multi_dst) | reg_match(id_src2_i, multi_dst2) |
                            reg_match(id_dst_i,  multi_dst) | reg_match(id_dst_i,  multi_dst2));

    // The multi-cycle result owns the writeback port in the cycle after count hits 1.
    assign collision = busy & (count == 6'd1) & ~is_multi;

    // Readiness is also gated by rst_n so nothing fires while reset is held.
    assign ready = rst_n & ~flush_i & ~(busy & is_multi) & ~hazard & ~collision;
    assign fire  = id_valid_i & ready;

    // Flush in the final BUSY cycle kills the multi-cycle writeback too.
    assign multi_done = busy & (count == 6'd1) & ~flush_i;

    assign id_ready_o = ready;
    assign ex_fire_o  = fire;
    assign ex_sel_o   = fire ? id_sel_i  : NOP_SEL;
    assign ex_dst_o   = fire ? id_dst_i  : 5'd0;
    assign ex_dst2_o  = fire ? id_dst2_i : 5'd0;
    assign busy_o     = busy;

    // State and countdown registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= 6'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state: a multi-cycle issue loads LAT-1 so the FSM leaves BUSY on
    // the edge ending cycle T+LAT-1 and the result appears in T+LAT.
    always_comb begin
        state_next = state;
        count_next = count;
        if (flush_i) begin
            state_next = IDLE;
            count_next = 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire && is_multi) begin
                        state_next = BUSY;
                        count_next = is_div ? DIV_CNT : MUL_CNT;
                    end
                end
                BUSY: begin
                    if (count == 6'd1) begin
                        state_next = IDLE;
                        count_next = 6'd0;
                    end else begin
                        count_next = count - 6'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = 6'd0;
                end
            endcase
        end
    end

    // Destination latch for the outstanding multi-cycle op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi_dst  <= 5'd0;
            multi_dst2 <= 5'd0;
        end else if (fire && is_multi) begin
            multi_dst  <= id_dst_i;
            multi_dst2 <= id_dst2_i;
        end
    end

    // Writeback stream: single-cycle results one cycle after issue, multi-cycle
    // results when the countdown expires. Collision blocking keeps them disjoint.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_o <= 1'b0;
            wb_multi_o <= 1'b0;
            wb_dst_o   <= 5'd0;
            wb_dst2_o  <= 5'd0;
        end else begin
            wb_valid_o <= 1'b0;
            wb_multi_o <= 1'b0;
            wb_dst_o   <= 5'd0;
            wb_dst2_o  <= 5'd0;
            if (multi_done) begin
                wb_valid_o <= 1'b1;
                wb_multi_o <= 1'b1;
                wb_dst_o   <= multi_dst;
                wb_dst2_o  <= multi_dst2;
            end else if (fire && !is_multi) begin
                wb_valid_o <= 1'b1;
                wb_dst_o   <= id_dst_i;
            end
        end
    end

`ifdef EXSCHED_PERF_EN
    // Free-running event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_o <= 32'd0;
            perf_stall_o <= 32'd0;
            perf_multi_o <= 32'd0;
        end else begin
            if (fire)
                perf_issue_o <= perf_issue_o + 32'd1;
            if (id_valid_i && !ready)
                perf_stall_o <= perf_stall_o + 32'd1;
            if (multi_done)
                perf_multi_o <= perf_multi_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_issue_sched.sv
// tb_ex_issue_sched
// Self-checking bench for ex_issue_sched. Expected writebacks are queued with
// their due cycle when an op fires; a negedge monitor matches them against
// the DUT writeback stream and also tracks the expected busy_o window.
// Build with EXSCHED_PERF_EN defined to exercise the performance counters.
`timescale 1ns/1ps

module tb_ex_issue_sched;

    localparam int DIV_LAT = 35;
    localparam int MUL_LAT = 2;
    localparam logic [9:0] NOP_SEL = 10'h200;
    localparam logic [9:0] SEL_DIV = 10'h008;
    localparam logic [9:0] SEL_MUL = 10'h080;
    localparam logic [9:0] SEL_ADD = 10'h020;

    typedef struct {
        logic [4:0] dst;
        logic [4:0] dst2;
        logic       multi;
        int         cyc;
    } wb_t;

    logic       clk, rst_n;
    logic       id_valid, id_ready, flush;
    logic [9:0] id_sel, ex_sel;
    logic [4:0] id_src1, id_src2, id_dst, id_dst2, ex_dst, ex_dst2, wb_dst, wb_dst2;
    logic       ex_fire, wb_valid, wb_multi, busy;
`ifdef EXSCHED_PERF_EN
    logic [31:0] perf_issue, perf_stall, perf_multi;
`endif

    wb_t sb[$];
    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;
    int  busy_lo = 0;
    int  busy_hi = -1;

    ex_issue_sched dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid), .id_ready_o(id_ready), .id_sel_i(id_sel),
        .id_src1_i(id_src1), .id_src2_i(id_src2), .id_dst_i(id_dst), .id_dst2_i(id_dst2),
        .flush_i(flush),
        .ex_fire_o(ex_fire), .ex_sel_o(ex_sel), .ex_dst_o(ex_dst), .ex_dst2_o(ex_dst2),
        .wb_valid_o(wb_valid), .wb_dst_o(wb_dst), .wb_dst2_o(wb_dst2), .wb_multi_o(wb_multi),
        .busy_o(busy)
`ifdef EXSCHED_PERF_EN
        ,
        .perf_issue_o(perf_issue), .perf_stall_o(perf_stall), .perf_multi_o(perf_multi)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: writeback scoreboard, busy window and idle Executer fields.
    always @(negedge clk) begin
        int  idx;
        wb_t e;
        bit  exp_busy;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL wb_missing: no writeback seen for dst=%0d, expected in cycle %0d", sb[i].dst, sb[i].cyc);
                sb.delete(i);
            end
        end
        if (wb_valid === 1'b1) begin
            checks++;
            idx = -1;
            foreach (sb[i]) if (idx < 0 && sb[i].cyc == cyc) idx = i;
            if (idx < 0) begin
                errors++;
                $display("[TB] FAIL wb_unexpected: got dst=%0d multi=%0b in cycle %0d, expected no writeback", wb_dst, wb_multi, cyc);
            end else begin
                e = sb[idx];
                sb.delete(idx);
                if (wb_dst !== e.dst || wb_dst2 !== e.dst2 || wb_multi !== e.multi) begin
                    errors++;
                    $display("[TB] FAIL wb_data: got dst=%0d dst2=%0d multi=%0b, expected dst=%0d dst2=%0d multi=%0b",
                             wb_dst, wb_dst2, wb_multi, e.dst, e.dst2, e.multi);
                end
            end
        end
        exp_busy = (rst_n === 1'b1) && (cyc >= busy_lo) && (cyc <= busy_hi);
        checks++;
        if (busy !== exp_busy) begin
            errors++;
            $display("[TB] FAIL busy: got %0b, expected %0b in cycle %0d", busy, exp_busy, cyc);
        end
        if (id_valid === 1'b0) begin
            checks++;
            if (ex_fire !== 1'b0 || ex_sel !== NOP_SEL || ex_dst !== 5'd0 || ex_dst2 !== 5'd0) begin
                errors++;
                $display("[TB] FAIL ex_idle: got fire=%0b sel=%h dst=%0d dst2=%0d, expected fire=0 sel=%h dst=0 dst2=0",
                         ex_fire, ex_sel, ex_dst, ex_dst2, NOP_SEL);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present an op and hold it until it fires; queue its expected writeback.
    task automatic issue_op(input logic [9:0] sel, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [4:0] d, input logic [4:0] d2,
                            output int t_fire, output int waited);
        wb_t e;
        bit  done;
        int  lat;
        done = 0; t_fire = -1; waited = 0;
        id_valid = 1'b1; id_sel = sel; id_src1 = s1; id_src2 = s2; id_dst = d; id_dst2 = d2;
        while (!done) begin
            @(negedge clk);
            checks++;
            if (id_ready === 1'b1) begin
                done = 1;
                t_fire = cyc;
                if (ex_fire !== 1'b1 || ex_sel !== sel || ex_dst !== d || ex_dst2 !== d2) begin
                    errors++;
                    $display("[TB] FAIL ex_issue: got fire=%0b sel=%h dst=%0d dst2=%0d, expected fire=1 sel=%h dst=%0d dst2=%0d",
                             ex_fire, ex_sel, ex_dst, ex_dst2, sel, d, d2);
                end
                e.dst = d;
                if (sel == SEL_DIV || sel == SEL_MUL) begin
                    lat = (sel == SEL_DIV) ? DIV_LAT : MUL_LAT;
                    e.dst2 = d2; e.multi = 1'b1; e.cyc = cyc + lat;
                    busy_lo = cyc + 1;
                    busy_hi = cyc + lat - 1;
                end else begin
                    e.dst2 = 5'd0; e.multi = 1'b0; e.cyc = cyc + 1;
                end
                sb.push_back(e);
            end else begin
                waited++;
                if (ex_fire !== 1'b0 || ex_sel !== NOP_SEL) begin
                    errors++;
                    $display("[TB] FAIL ex_stall: got fire=%0b sel=%h, expected fire=0 sel=%h", ex_fire, ex_sel, NOP_SEL);
                end
                if (waited > 100) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL issue_timeout: op sel=%h not accepted after %0d cycles, expected acceptance", sel, waited);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        id_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0 || wb_multi !== 1'b0 || wb_dst !== 5'd0 || wb_dst2 !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_wb: got busy=%0b wb_valid=%0b multi=%0b dst=%0d dst2=%0d, expected all 0",
                     busy, wb_valid, wb_multi, wb_dst, wb_dst2);
        end
        checks++;
        if (ex_fire !== 1'b0 || ex_sel !== NOP_SEL) begin
            errors++;
            $display("[TB] FAIL reset_ex: got fire=%0b sel=%h, expected fire=0 sel=%h", ex_fire, ex_sel, NOP_SEL);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_single();
        int t, w;
        issue_op(SEL_ADD, 5'd1, 5'd2, 5'd5, 5'd0, t, w);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("[TB] FAIL single_wait: got %0d stall cycles, expected 0", w);
        end
        issue_op(10'h3ff, 5'd6, 5'd7, 5'd31, 5'd9, t, w);
        idle(2);
    endtask

    task automatic test_div();
        int t0, t1, w;
        issue_op(SEL_DIV, 5'd1, 5'd2, 5'd3, 5'd4, t0, w);
        issue_op(SEL_DIV, 5'd5, 5'd6, 5'd6, 5'd0, t1, w);
        checks++;
        if (t1 != t0 + DIV_LAT || w != DIV_LAT - 1) begin
            errors++;
            $display("[TB] FAIL div_second: fired at +%0d after %0d stalls, expected +%0d after %0d",
                     t1 - t0, w, DIV_LAT, DIV_LAT - 1);
        end
        idle(DIV_LAT + 2);
    endtask

    task automatic test_hazard();
        int t0, t, w;
        issue_op(SEL_DIV, 5'd1, 5'd2, 5'd3, 5'd0, t0, w);
        issue_op(SEL_ADD, 5'd7, 5'd8, 5'd9, 5'd0, t, w);
        checks++;
        if (t != t0 + 1) begin
            errors++;
            $display("[TB] FAIL hazard_indep: fired at +%0d, expected +1", t - t0);
        end
        issue_op(SEL_ADD, 5'd0, 5'd0, 5'd11, 5'd0, t, w);
        checks++;
        if (t != t0 + 2) begin
            errors++;
            $display("[TB] FAIL hazard_r0: fired at +%0d, expected +2", t - t0);
        end
        issue_op(SEL_ADD, 5'd3, 5'd8, 5'd10, 5'd0, t, w);
        checks++;
        if (t != t0 + DIV_LAT) begin
            errors++;
            $display("[TB] FAIL hazard_raw: fired at +%0d, expected +%0d", t - t0, DIV_LAT);
        end
        idle(3);
    endtask

    task automatic test_collision();
        int t0, t, w;
        issue_op(SEL_MUL, 5'd1, 5'd2, 5'd12, 5'd13, t0, w);
        issue_op(SEL_ADD, 5'd7, 5'd8, 5'd9, 5'd0, t, w);
        checks++;
        if (t != t0 + 2 || w != 1) begin
            errors++;
            $display("[TB] FAIL collision: fired at +%0d after %0d stalls, expected +2 after 1", t - t0, w);
        end
        idle(3);
    endtask

    task automatic test_flush();
        int t0, w;
        issue_op(SEL_DIV, 5'd1, 5'd2, 5'd14, 5'd15, t0, w);
        id_sel = SEL_ADD; id_src1 = 5'd7; id_src2 = 5'd8; id_dst = 5'd9; id_dst2 = 5'd0;
        while (cyc < t0 + 12) begin
            if (cyc == t0 + 10) begin
                flush = 1'b1;
                for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].cyc > cyc) sb.delete(i);
                busy_hi = cyc;
            end else begin
                flush = 1'b0;
            end
            @(negedge clk);
            if (cyc >= t0 + 9 && cyc <= t0 + 11) begin
                checks++;
                if (id_ready !== (cyc != t0 + 10)) begin
                    errors++;
                    $display("[TB] FAIL flush_ready: got %0b at +%0d, expected %0b", id_ready, cyc - t0, cyc != t0 + 10);
                end
            end
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        while (cyc <= t0 + 41) idle(1);
    endtask

    task automatic test_reset_mid();
        int t0, w;
        issue_op(SEL_DIV, 5'd1, 5'd2, 5'd16, 5'd17, t0, w);
        idle(5);
        id_valid = 1'b1; id_sel = SEL_ADD; id_src1 = 5'd7; id_src2 = 5'd8; id_dst = 5'd9; id_dst2 = 5'd0;
        rst_n = 1'b0;
        sb.delete();
        busy_hi = -1;
        #1;
        checks++;
        if (busy !== 1'b0 || wb_valid !== 1'b0 || wb_multi !== 1'b0 || wb_dst !== 5'd0 || wb_dst2 !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_wb: got busy=%0b wb_valid=%0b multi=%0b, expected all 0", busy, wb_valid, wb_multi);
        end
        checks++;
        if (ex_fire !== 1'b0 || ex_sel !== NOP_SEL || ex_dst !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_ex: got fire=%0b sel=%h dst=%0d, expected fire=0 sel=%h dst=0", ex_fire, ex_sel, ex_dst, NOP_SEL);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        rst_n = 1'b1;
        idle(DIV_LAT + 5);
    endtask

`ifdef EXSCHED_PERF_EN
    task automatic test_perf();
        int t, w;
        rst_n = 1'b0;
        sb.delete();
        busy_hi = -1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (perf_issue !== 32'd0 || perf_stall !== 32'd0 || perf_multi !== 32'd0) begin
            errors++;
            $display("[TB] FAIL perf_reset: got issue=%0d stall=%0d multi=%0d, expected 0 0 0", perf_issue, perf_stall, perf_multi);
        end
        @(posedge clk);
        #1;
        issue_op(SEL_ADD, 5'd1, 5'd2, 5'd5, 5'd0, t, w);
        issue_op(SEL_ADD, 5'd1, 5'd2, 5'd6, 5'd0, t, w);
        idle(2);
        id_valid = 1'b1; id_sel = SEL_ADD; id_src1 = 5'd1; id_src2 = 5'd2; id_dst = 5'd7; id_dst2 = 5'd0;
        flush = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (id_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL perf_flush_ready: got %0b, expected 0", id_ready);
            end
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        issue_op(SEL_ADD, 5'd1, 5'd2, 5'd7, 5'd0, t, w);
        @(negedge clk);
        checks++;
        if (perf_issue !== 32'd3 || perf_stall !== 32'd2 || perf_multi !== 32'd0) begin
            errors++;
            $display("[TB] FAIL perf_counts: got issue=%0d stall=%0d multi=%0d, expected 3 2 0", perf_issue, perf_stall, perf_multi);
        end
        @(posedge clk);
        #1;
        issue_op(SEL_MUL, 5'd1, 5'd2, 5'd8, 5'd9, t, w);
        idle(3);
        @(negedge clk);
        checks++;
        if (perf_issue !== 32'd4 || perf_multi !== 32'd1) begin
            errors++;
            $display("[TB] FAIL perf_multi: got issue=%0d multi=%0d, expected 4 1", perf_issue, perf_multi);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0;
        id_sel = SEL_ADD; id_src1 = 5'd0; id_src2 = 5'd0; id_dst = 5'd0; id_dst2 = 5'd0;
        $display("[TB] starting ex_issue_sched bench");
        test_reset();
        test_single();
        test_div();
        test_hazard();
        test_collision();
        test_flush();
        test_reset_mid();
`ifdef EXSCHED_PERF_EN
        test_perf();
`endif
        idle(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain: got %0d pending writebacks, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
